// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: text segment base,
// PC increment and the fetch state encoding.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam int          PC_INCR   = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: hazard/branch inputs, ROM address/data and the IF/ID
// register. The sequencer is the master; ROM, hazard unit and decode are the slave.
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic [DATA_WIDTH-1:0] instruction_in;
  logic [DATA_WIDTH-1:0] pc_out;
  logic [DATA_WIDTH-1:0] ifid_instruction;
  logic [DATA_WIDTH-1:0] ifid_pc_plus4;
  logic                  ifid_valid;
  logic                  fetch_fault;
  logic [DATA_WIDTH-1:0] fault_addr;
  logic [31:0]           fetch_count;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  instruction_in,
    output pc_out,
    output ifid_instruction,
    output ifid_pc_plus4,
    output ifid_valid,
    output fetch_fault,
    output fault_addr,
    output fetch_count
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_target,
    output instruction_in,
    input  pc_out,
    input  ifid_instruction,
    input  ifid_pc_plus4,
    input  ifid_valid,
    input  fetch_fault,
    input  fault_addr,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_sequencer_pc_range_check.sv
// Combinational legality check of a fetch address: word aligned and
// inside [TEXT_BASE, TEXT_BASE + 4*MEMORY_DEPTH), compared unsigned.
module pc_range_check #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(mips_pkg::TEXT_BASE),
  parameter int                    MEMORY_DEPTH = 2048
) (
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  legal
);
  import mips_pkg::*;

  // One extra bit so the upper bound cannot wrap for a base near the top.
  localparam logic [DATA_WIDTH:0] LO_BOUND = {1'b0, TEXT_BASE};
  localparam logic [DATA_WIDTH:0] HI_BOUND = LO_BOUND + (DATA_WIDTH+1)'(PC_INCR * MEMORY_DEPTH);

  logic [DATA_WIDTH:0] pc_ext;
  logic                in_range;
  logic                aligned;

  assign pc_ext   = {1'b0, pc};
  assign in_range = (pc_ext >= LO_BOUND) && (pc_ext < HI_BOUND);
  assign aligned  = (pc[1:0] == 2'b00);
  assign legal    = in_range && aligned;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the ROM and loads
// the IF/ID register, with stall, redirect/flush and sticky fetch faults.
//
// state | meaning
// BOOT  | one bubble cycle after reset, stall/redirect ignored
// RUN   | fetching: redirect > fault check > stall > advance
// FAULT | terminal until reset, PC frozen, IF/ID empty
module fetch_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(mips_pkg::TEXT_BASE),
  parameter int                    MEMORY_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);
  import mips_pkg::*;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(PC_INCR);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ifid_instruction;
  logic [DATA_WIDTH-1:0] ifid_pc_plus4;
  logic                  ifid_valid;
  logic                  fetch_fault;
  logic [DATA_WIDTH-1:0] fault_addr;
  logic [31:0]           fetch_count;
  logic [DATA_WIDTH-1:0] pc_next_seq;
  logic                  pc_legal;

  pc_range_check #(
    .DATA_WIDTH   (DATA_WIDTH),
    .TEXT_BASE    (TEXT_BASE),
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_range (
    .pc    (pc),
    .legal (pc_legal)
  );

  // Modulo add: a wrap lands out of range and faults on the next edge.
  assign pc_next_seq = pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= BOOT;
      pc               <= TEXT_BASE;
      ifid_instruction <= '0;
      ifid_pc_plus4    <= '0;
      ifid_valid       <= 1'b0;
      fetch_fault      <= 1'b0;
      fault_addr       <= '0;
      fetch_count      <= '0;
    end else begin
      case (state)
        BOOT: begin
          ifid_valid <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          if (bus.redirect_valid) begin
            // Target is taken unchecked; an illegal one faults next edge.
            pc         <= bus.redirect_target;
            ifid_valid <= 1'b0;
          end else if (!pc_legal) begin
            state       <= FAULT;
            fault_addr  <= pc;
            fetch_fault <= 1'b1;
            ifid_valid  <= 1'b0;
          end else if (!bus.stall) begin
            ifid_instruction <= bus.instruction_in;
            ifid_pc_plus4    <= pc_next_seq;
            ifid_valid       <= 1'b1;
            pc               <= pc_next_seq;
            fetch_count      <= fetch_count + 32'd1;
          end
        end
        FAULT: begin
          ifid_valid <= 1'b0;
        end
        default: begin
          state      <= BOOT;
          pc         <= TEXT_BASE;
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out           = pc;
  assign bus.ifid_instruction = ifid_instruction;
  assign bus.ifid_pc_plus4    = ifid_pc_plus4;
  assign bus.ifid_valid       = ifid_valid;
  assign bus.fetch_fault      = fetch_fault;
  assign bus.fault_addr       = fault_addr;
  assign bus.fetch_count      = fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected outputs are queued with each
// stimulus step and popped/compared one edge later.
module tb_fetch_sequencer;

  localparam logic [31:0] B = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.DATA_WIDTH(32)) bus ();

  fetch_sequencer #(
    .DATA_WIDTH   (32),
    .TEXT_BASE    (32'h0040_0000),
    .MEMORY_DEPTH (2048)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == B)             return 32'h2008_0001;
    else if (a == B + 32'd4) return 32'h2009_0002;
    else                    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.instruction_in = rom_word(bus.pc_out);

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] count;
    logic        fault;
    logic [31:0] faddr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic drive(input logic s, input logic rv, input logic [31:0] t);
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = t;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic valid,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic [31:0] count, input logic fault,
                            input logic [31:0] faddr);
    exp_t e;
    e.tag = tag; e.pc = pc; e.valid = valid; e.instr = instr; e.pc4 = pc4;
    e.count = count; e.fault = fault; e.faddr = faddr;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk(e.tag, "pc_out",           bus.pc_out,                  e.pc);
      chk(e.tag, "ifid_valid",       {31'd0, bus.ifid_valid},     {31'd0, e.valid});
      chk(e.tag, "ifid_instruction", bus.ifid_instruction,        e.instr);
      chk(e.tag, "ifid_pc_plus4",    bus.ifid_pc_plus4,           e.pc4);
      chk(e.tag, "fetch_count",      bus.fetch_count,             e.count);
      chk(e.tag, "fetch_fault",      {31'd0, bus.fetch_fault},    {31'd0, e.fault});
      chk(e.tag, "fault_addr",       bus.fault_addr,              e.faddr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    expect_out("reset", B, 0, 0, 0, 0, 0, 0); tick();
    reset = 1'b1;
    expect_out("boot", B, 0, 0, 0, 0, 0, 0); tick();
    expect_out("first", B+4, 1, 32'h2008_0001, B+4, 1, 0, 0); tick();
    expect_out("second", B+8, 1, 32'h2009_0002, B+8, 2, 0, 0); tick();

    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      expect_out("stall", B+8, 1, 32'h2009_0002, B+8, 2, 0, 0); tick();
    end
    drive(1'b0, 1'b0, 32'd0);
    expect_out("resume", B+32'hC, 1, rom_word(B+8), B+32'hC, 3, 0, 0); tick();

    drive(1'b1, 1'b1, B+32'h20);
    expect_out("redir_over_stall", B+32'h20, 0, rom_word(B+8), B+32'hC, 3, 0, 0); tick();
    drive(1'b0, 1'b0, 32'd0);
    expect_out("redir_target", B+32'h24, 1, rom_word(B+32'h20), B+32'h24, 4, 0, 0); tick();

    drive(1'b0, 1'b1, B+32'h22);
    expect_out("redir_misalign", B+32'h22, 0, rom_word(B+32'h20), B+32'h24, 4, 0, 0); tick();
    drive(1'b0, 1'b0, 32'd0);
    expect_out("fault_raise", B+32'h22, 0, rom_word(B+32'h20), B+32'h24, 4, 1, B+32'h22); tick();
    drive(1'b1, 1'b1, B);
    expect_out("fault_hold", B+32'h22, 0, rom_word(B+32'h20), B+32'h24, 4, 1, B+32'h22); tick();

    reset = 1'b0;
    expect_out("reset_in_fault", B, 0, 0, 0, 0, 0, 0); tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    expect_out("boot2", B, 0, 0, 0, 0, 0, 0); tick();

    drive(1'b0, 1'b1, B+32'h1FF8);
    expect_out("jump_near_end", B+32'h1FF8, 0, 0, 0, 0, 0, 0); tick();
    drive(1'b0, 1'b0, 32'd0);
    expect_out("word_2046", B+32'h1FFC, 1, rom_word(B+32'h1FF8), B+32'h1FFC, 1, 0, 0); tick();
    expect_out("last_word", B+32'h2000, 1, rom_word(B+32'h1FFC), B+32'h2000, 2, 0, 0); tick();
    expect_out("past_end", B+32'h2000, 0, rom_word(B+32'h1FFC), B+32'h2000, 2, 1, B+32'h2000); tick();

    reset = 1'b0;
    expect_out("reset_after_end", B, 0, 0, 0, 0, 0, 0); tick();
    reset = 1'b1;
    expect_out("boot3", B, 0, 0, 0, 0, 0, 0); tick();
    expect_out("run_a", B+4, 1, 32'h2008_0001, B+4, 1, 0, 0); tick();

    reset = 1'b0;
    drive(1'b0, 1'b1, B+32'h40);
    expect_out("reset_mid_redirect", B, 0, 0, 0, 0, 0, 0); tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, B+32'h40);
    expect_out("boot_ignores_inputs", B, 0, 0, 0, 0, 0, 0); tick();
    drive(1'b0, 1'b0, 32'd0);
    expect_out("run_b", B+4, 1, 32'h2008_0001, B+4, 1, 0, 0); tick();

    drive(1'b0, 1'b1, 32'h003F_FFFC);
    expect_out("jump_below", 32'h003F_FFFC, 0, 32'h2008_0001, B+4, 1, 0, 0); tick();
    drive(1'b0, 1'b0, 32'd0);
    expect_out("fault_below", 32'h003F_FFFC, 0, 32'h2008_0001, B+4, 1, 1, 32'h003F_FFFC); tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d expectations left unconsumed", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
